paddle_ai_driver: RTL and testbench

Computer opponent for the Pong game: drives the active-low up/down button inputs of one paddle in the paddle block from the ball position. It sits between the ball and paddle blocks on the 1 ms game tick, and replaces the two physical push-buttons of that player. The paddle's reported centre y is fed back as the control error. A reaction delay, a move-rate divider and a dead-band keep the opponent beatable.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/lfsr8.sv | 33 +++
 rtl/paddle_ai_driver.sv | 179 +++++++++++++++++
 tb/tb_paddle_ai_driver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong constants and the AI opponent state type.
package pong_pkg;

    localparam int H_ACTIVE      = 640;
    localparam int V_ACTIVE      = 480;
    localparam int PADDLE_WIDTH  = 20;
    localparam int PADDLE_HEIGHT = 40;

    localparam int Y_MID = V_ACTIVE / 2;
    localparam int Y_MIN = PADDLE_HEIGHT / 2;
    localparam int Y_MAX = V_ACTIVE - PADDLE_HEIGHT / 2;

    typedef enum logic [1:0] {
        ST_RETURN  = 2'd0,
        ST_REACT   = 2'd1,
        ST_TRACK   = 2'd2,
        ST_ILLEGAL = 2'd3
    } ai_state_e;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded with 8'hA5.
module lfsr8
    import pong_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    always_comb begin
        fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], fb};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/paddle_ai_driver.sv
// Pong computer opponent: drives one paddle's active-low buttons.
// Define PONG_AI_JITTER_EN for LFSR-based aim offset.
module paddle_ai_driver
    import pong_pkg::*;
#(
    parameter int REACT_MS = 50,
    parameter int MOVE_DIV = 2,
    parameter int DEADBAND = 4,
    parameter int SIDE     = 1
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic [9:0] y_paddle,
    output logic       btn_up_n,
    output logic       btn_dn_n,
    output logic [1:0] state
);

    localparam int RC_W = (REACT_MS > 1) ? $clog2(REACT_MS) : 1;
    localparam int DV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REACT_MS - 1);
    localparam logic [DV_W-1:0] DV_LAST = DV_W'(MOVE_DIV - 1);

    localparam logic signed [11:0] T_MID = 12'(Y_MID);
    localparam logic signed [11:0] T_MIN = 12'(Y_MIN);
    localparam logic signed [11:0] T_MAX = 12'(Y_MAX);
    localparam logic signed [10:0] DB_P  = 11'(DEADBAND);
    localparam logic signed [10:0] DB_N  = -DB_P;

    ai_state_e state_q, state_d;

    logic [9:0]      x_prev_q;
    logic            appr_q;
    logic            appr;
    logic [RC_W-1:0] react_cnt_q, react_cnt_d;
    logic [DV_W-1:0] div_cnt_q, div_cnt_d;
    logic            up_n_q, up_n_d;
    logic            dn_n_q, dn_n_d;
    logic signed [5:0] offset_q;

    logic signed [11:0] tgt_raw;
    logic signed [11:0] tgt_clip;
    logic signed [10:0] err;
    logic               want_up;
    logic               want_dn;
    logic               drive;
    logic               slot;
    logic               take_off;

    // A stationary ball keeps the last known direction.
    always_comb begin
        appr = appr_q;
        if (x_ball > x_prev_q) begin
            appr = (SIDE != 0);
        end else if (x_ball < x_prev_q) begin
            appr = (SIDE == 0);
        end
    end

    always_comb begin
        tgt_raw = T_MID;
        if (state_q == ST_TRACK) begin
            tgt_raw = $signed({2'b00, y_ball})
                    + {{6{offset_q[5]}}, offset_q};
        end
        tgt_clip = tgt_raw;
        if (tgt_raw < T_MIN) begin
            tgt_clip = T_MIN;
        end else if (tgt_raw > T_MAX) begin
            tgt_clip = T_MAX;
        end
        err     = tgt_clip[10:0] - $signed({1'b0, y_paddle});
        want_up = (err < DB_N);
        want_dn = (err > DB_P) && !want_up;
    end

    always_comb begin
        state_d     = state_q;
        react_cnt_d = react_cnt_q;
        div_cnt_d   = (div_cnt_q == DV_LAST) ? '0 : div_cnt_q + 1'b1;
        slot        = (div_cnt_q == '0);
        drive       = 1'b0;
        up_n_d      = 1'b1;
        dn_n_d      = 1'b1;

        unique case (state_q)
            ST_RETURN: begin
                drive = 1'b1;
                if (appr) begin
                    state_d     = ST_REACT;
                    react_cnt_d = '0;
                end
            end
            ST_REACT: begin
                react_cnt_d = react_cnt_q + 1'b1;
                if (!appr) begin
                    state_d = ST_RETURN;
                end else if (react_cnt_q == RC_LAST) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                drive = 1'b1;
                if (!appr) begin
                    state_d = ST_RETURN;
                end
            end
            default: begin
                state_d = ST_RETURN;
            end
        endcase

        if (drive && slot) begin
            up_n_d = !want_up;
            dn_n_d = !want_dn;
        end

        if (!enable) begin
            state_d     = ST_RETURN;
            react_cnt_d = '0;
            div_cnt_d   = '0;
            up_n_d      = 1'b1;
            dn_n_d      = 1'b1;
        end

        take_off = (state_q == ST_REACT) && (state_d == ST_TRACK);
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state_q     <= ST_RETURN;
            x_prev_q    <= '0;
            appr_q      <= 1'b0;
            react_cnt_q <= '0;
            div_cnt_q   <= '0;
            up_n_q      <= 1'b1;
            dn_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_prev_q    <= x_ball;
            appr_q      <= appr;
            react_cnt_q <= react_cnt_d;
            div_cnt_q   <= div_cnt_d;
            up_n_q      <= up_n_d;
            dn_n_q      <= dn_n_d;
        end
    end

`ifdef PONG_AI_JITTER_EN
    logic [7:0] lfsr;

    lfsr8 u_lfsr (
        .clk_i   (clk_1ms),
        .rst_n_i (reset),
        .en_i    (1'b1),
        .lfsr_o  (lfsr)
    );

    // Aim error picked once per rally, centred on zero.
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            offset_q <= '0;
        end else if (take_off) begin
            offset_q <= $signed({1'b0, lfsr[4:0]}) - 6'sd16;
        end
    end
`else
    assign offset_q = '0;
`endif

    assign btn_up_n = up_n_q;
    assign btn_dn_n = dn_n_q;
    assign state    = state_q;

endmodule

// File: tb/tb_paddle_ai_driver.sv
// Directed self-checking bench for paddle_ai_driver.
module tb_paddle_ai_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] x = 10'd400;
    logic [9:0] yb = 10'd0;
    logic [9:0] yp = 10'd0;

    logic       up, dn, up4, dn4;
    logic [1:0] st, st4;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int off = 0;
    int lows, ups4, both, first, second;

    always #5 clk = ~clk;

    paddle_ai_driver #(
        .REACT_MS(3), .MOVE_DIV(1), .DEADBAND(4), .SIDE(1)
    ) dut (
        .clk_1ms  (clk),
        .reset    (reset),
        .enable   (enable),
        .x_ball   (x),
        .y_ball   (yb),
        .y_paddle (yp),
        .btn_up_n (up),
        .btn_dn_n (dn),
        .state    (st)
    );

    paddle_ai_driver #(
        .REACT_MS(3), .MOVE_DIV(4), .DEADBAND(4), .SIDE(1)
    ) dut4 (
        .clk_1ms  (clk),
        .reset    (reset),
        .enable   (enable),
        .x_ball   (x),
        .y_ball   (yb),
        .y_paddle (yp),
        .btn_up_n (up4),
        .btn_dn_n (dn4),
        .state    (st4)
    );

`ifdef PONG_AI_JITTER_EN
    logic [7:0] m, m_last;
    always @(posedge clk) begin
        if (!reset) begin
            m      <= 8'hA5;
            m_last <= 8'hA5;
        end else begin
            m_last <= m;
            m      <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic u,
                           input logic d, input logic [1:0] s);
        chk({tag, "_up"}, 16'(up), 16'(u));
        chk({tag, "_dn"}, 16'(dn), 16'(d));
        chk({tag, "_st"}, 16'(st), 16'(s));
    endtask

    task automatic step_x();
        x = x + 10'd1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        x = 10'd400;
        yb = 10'd123;
        yp = 10'd77;
        repeat (5) begin
            tick();
            chk_out("reset", 1'b1, 1'b1, 2'd0);
        end

        reset = 1'b1;
        enable = 1'b0;
        yp = 10'd300;
        tick();
        chk_out("disabled", 1'b1, 1'b1, 2'd0);

        enable = 1'b1;
        x = 10'd399;
        tick();
        chk_out("ret_up", 1'b0, 1'b1, 2'd0);
        yp = 10'd243;
        tick();
        chk_out("ret_db", 1'b1, 1'b1, 2'd0);
        yp = 10'd236;
        tick();
        chk_out("ret_db_edge", 1'b1, 1'b1, 2'd0);
        yp = 10'd235;
        tick();
        chk_out("ret_dn", 1'b1, 1'b0, 2'd0);

        yb = 10'd100;
        yp = 10'd240;
        x = 10'd400;
        tick();
        chk_out("react1", 1'b1, 1'b1, 2'd1);
        step_x();
        chk_out("react2", 1'b1, 1'b1, 2'd1);
        step_x();
        chk_out("react3", 1'b1, 1'b1, 2'd1);
        step_x();
        chk_out("track_in", 1'b1, 1'b1, 2'd2);
`ifdef PONG_AI_JITTER_EN
        off = int'({1'b0, m_last[4:0]}) - 16;
        chk("offset", 16'(int'(dut.offset_q) + 16), 16'(off + 16));
`endif
        step_x();
        chk_out("track_up", 1'b0, 1'b1, 2'd2);

        yb = 10'(244 - off);
        step_x();
        chk_out("trk_db", 1'b1, 1'b1, 2'd2);
        yb = 10'(245 - off);
        step_x();
        chk_out("trk_dn", 1'b1, 1'b0, 2'd2);
        yb = 10'd5;
        yp = 10'd20;
        step_x();
        chk_out("trk_clamp_lo", 1'b1, 1'b1, 2'd2);
        yp = 10'd24;
        step_x();
        chk_out("trk_clamp_lo4", 1'b1, 1'b1, 2'd2);
        yb = 10'd600;
        yp = 10'd460;
        step_x();
        chk_out("trk_clamp_hi", 1'b1, 1'b1, 2'd2);

        yb = 10'(290 - off);
        yp = 10'd240;
        lows = 0;
        ups4 = 0;
        both = 0;
        first = -1;
        second = -1;
        for (int i = 0; i < 8; i++) begin
            step_x();
            chk("rate1_dn", 16'(dn), 16'd0);
            if (!dn4) begin
                lows++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (!up4) ups4++;
            if (!up4 && !dn4) both++;
        end
        chk("rate4_lows", 16'(lows), 16'd2);
        chk("rate4_gap", 16'(second - first), 16'd4);
        chk("rate4_up", 16'(ups4), 16'd0);
        chk("rate4_both", 16'(both), 16'd0);
        chk("rate4_st", 16'(st4), 16'd2);

        reset = 1'b0;
        step_x();
        chk_out("rst_trk", 1'b1, 1'b1, 2'd0);
        chk("rst_trk4_dn", 16'(dn4), 16'd1);
        reset = 1'b1;

        x = 10'd500;
        tick();
        chk_out("react_again", 1'b1, 1'b1, 2'd1);
        enable = 1'b0;
        step_x();
        chk_out("en_off", 1'b1, 1'b1, 2'd0);
        step_x();
        chk_out("en_hold", 1'b1, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
